// File: rtl/send_data_fsm.sv
// ============================================================================
// Module      : send_data_fsm
// Description : Streams a snapshotted datapath frame followed by a data memory
//               dump over a byte-wide UART transmit handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module send_data_fsm #(
  parameter int UART_BITS       = 8,
  parameter int PROC_BITS       = 32,
  parameter int FRAME_BYTES     = 64,
  parameter int MEM_WORDS       = 32,
  parameter int DATA_ADDRS_BITS = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [FRAME_BYTES*UART_BITS-1:0] i_frame,
  input  logic [PROC_BITS-1:0]             i_mem_data,
  input  logic                             i_tx_done,
  output logic                             o_tx_start,
  output logic [UART_BITS-1:0]             o_tx_data,
  output logic                             o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0]       o_debug_read_address,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int FRAME_W    = FRAME_BYTES * UART_BITS;
  localparam int WORD_BYTES = PROC_BITS / UART_BITS;
  localparam int KW         = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int BW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [KW-1:0]              K_LAST = KW'(FRAME_BYTES - 1);
  localparam logic [BW-1:0]              B_LAST = BW'(WORD_BYTES - 1);
  localparam logic [DATA_ADDRS_BITS-1:0] W_LAST = DATA_ADDRS_BITS'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_FRAME  = 3'd1,
    WAIT_FRAME  = 3'd2,
    MEM_READ    = 3'd3,
    MEM_CAPTURE = 3'd4,
    SEND_MEM    = 3'd5,
    WAIT_MEM    = 3'd6,
    DONE        = 3'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [FRAME_W-1:0]         frame_q, frame_d;
  logic [PROC_BITS-1:0]       word_q, word_d;
  logic [KW-1:0]              k_q, k_d;
  logic [BW-1:0]              b_q, b_d;
  logic [DATA_ADDRS_BITS-1:0] w_q, w_d;

  logic                       tx_start_w;
  logic [UART_BITS-1:0]       tx_data_w;
  logic                       rd_en_w;
  logic [DATA_ADDRS_BITS-1:0] rd_addr_w;
  logic                       busy_w;
  logic                       done_w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      word_q  <= '0;
      k_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      word_q  <= word_d;
      k_q     <= k_d;
      b_q     <= b_d;
      w_q     <= w_d;
    end
  end

  // Frame and word registers shift left per byte, so the byte on the wire is
  // always the top slice and stays put until the next advance.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    word_d     = word_q;
    k_d        = k_q;
    b_d        = b_q;
    w_d        = w_q;
    tx_start_w = 1'b0;
    tx_data_w  = '0;
    rd_en_w    = 1'b0;
    rd_addr_w  = '0;
    busy_w     = 1'b1;
    done_w     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_w = 1'b0;
        if (i_start) begin
          frame_d = i_frame;
          k_d     = '0;
          state_d = SEND_FRAME;
        end
      end
      SEND_FRAME: begin
        tx_start_w = 1'b1;
        tx_data_w  = frame_q[FRAME_W-1 -: UART_BITS];
        state_d    = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        tx_data_w = frame_q[FRAME_W-1 -: UART_BITS];
        if (i_tx_done) begin
          if (k_q < K_LAST) begin
            k_d     = k_q + KW'(1);
            frame_d = frame_q << UART_BITS;
            state_d = SEND_FRAME;
          end else begin
            w_d     = '0;
            state_d = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        rd_en_w   = 1'b1;
        rd_addr_w = w_q;
        state_d   = MEM_CAPTURE;
      end
      MEM_CAPTURE: begin
        rd_en_w   = 1'b1;
        rd_addr_w = w_q;
        word_d    = i_mem_data;
        b_d       = '0;
        state_d   = SEND_MEM;
      end
      SEND_MEM: begin
        tx_start_w = 1'b1;
        tx_data_w  = word_q[PROC_BITS-1 -: UART_BITS];
        state_d    = WAIT_MEM;
      end
      WAIT_MEM: begin
        tx_data_w = word_q[PROC_BITS-1 -: UART_BITS];
        if (i_tx_done) begin
          if (b_q < B_LAST) begin
            b_d     = b_q + BW'(1);
            word_d  = word_q << UART_BITS;
            state_d = SEND_MEM;
          end else if (w_q < W_LAST) begin
            w_d     = w_q + DATA_ADDRS_BITS'(1);
            state_d = MEM_READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_w  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are held low while reset is asserted, not just after the edge.
  assign o_tx_start           = tx_start_w & rst;
  assign o_tx_data            = tx_data_w & {UART_BITS{rst}};
  assign o_debug_read_data    = rd_en_w & rst;
  assign o_debug_read_address = rd_addr_w & {DATA_ADDRS_BITS{rst}};
  assign o_busy               = busy_w & rst;
  assign o_done               = done_w & rst;

endmodule

`default_nettype wire

// File: tb/tb_send_data_fsm.sv
// ============================================================================
// Module      : tb_send_data_fsm
// Description : Directed self-checking bench for send_data_fsm (2-byte frame,
//               two 32-bit memory words, UART done 10 cycles after each start).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_send_data_fsm;

  localparam int UB  = 8;
  localparam int PB  = 32;
  localparam int FB  = 2;
  localparam int MW  = 2;
  localparam int DAB = 7;

  logic           clk        = 1'b0;
  logic           rst        = 1'b0;
  logic           i_start    = 1'b0;
  logic [FB*UB-1:0] i_frame  = '0;
  logic [PB-1:0]  i_mem_data = '0;
  logic           i_tx_done  = 1'b0;
  logic           o_tx_start;
  logic [UB-1:0]  o_tx_data;
  logic           o_debug_read_data;
  logic [DAB-1:0] o_debug_read_address;
  logic           o_busy;
  logic           o_done;

  always #5 clk = ~clk;

  send_data_fsm #(
    .UART_BITS      (UB),
    .PROC_BITS      (PB),
    .FRAME_BYTES    (FB),
    .MEM_WORDS      (MW),
    .DATA_ADDRS_BITS(DAB)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_start             (i_start),
    .i_frame             (i_frame),
    .i_mem_data          (i_mem_data),
    .i_tx_done           (i_tx_done),
    .o_tx_start          (o_tx_start),
    .o_tx_data           (o_tx_data),
    .o_debug_read_data   (o_debug_read_data),
    .o_debug_read_address(o_debug_read_address),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  // Synchronous-read data memory with one cycle of latency
  logic [PB-1:0] mem [0:1];
  always @(posedge clk) begin
    if (o_debug_read_data)
      i_mem_data <= (o_debug_read_address < DAB'(2)) ? mem[o_debug_read_address[0]] : 'x;
  end

  // UART responder / monitor, evaluated 1 time unit after each rising edge
  logic [7:0]     byte_log [$];
  logic [DAB-1:0] rd_log [$];
  int             done_cnt    = 0;
  int             rd_overlap  = 0;
  int             stable_err  = 0;
  int             addr_err    = 0;
  int             idle_tx     = 0;
  int             cnt         = 0;
  logic [7:0]     held        = '0;
  logic           resp_clear  = 1'b0;
  logic           inj_done    = 1'b0;

  always begin
    @(posedge clk);
    #1;
    i_tx_done = 1'b0;
    if (resp_clear) cnt = 0;
    else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) i_tx_done = 1'b1;
    end
    if (inj_done) i_tx_done = 1'b1;
    if (o_tx_start) begin
      if (!o_busy) idle_tx++;
      byte_log.push_back(o_tx_data);
      held = o_tx_data;
      cnt  = 10;
    end else if (cnt > 0 && o_tx_data !== held) begin
      stable_err++;
    end
    if (o_debug_read_data) begin
      rd_log.push_back(o_debug_read_address);
      if (cnt != 0) rd_overlap++;
    end else if (o_debug_read_address !== '0) begin
      addr_err++;
    end
    if (o_done) done_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start got %b want 0", o_tx_start); end
    n_cmp++; if (o_tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
    n_cmp++; if (o_debug_read_data !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", o_debug_read_data); end
    n_cmp++; if (o_debug_read_address !== '0) begin n_bad++; $display("FAIL reset_rd_addr got %h want 0", o_debug_read_address); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", o_done); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", o_busy); end
  endtask

  task automatic test_basic_dump();
    logic [7:0] e [10];
    int base, rb, d0, ov0, se0, ae0, it0;
    bit ok;
    e = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    base = byte_log.size(); rb = rd_log.size(); d0 = done_cnt;
    ov0 = rd_overlap; se0 = stable_err; ae0 = addr_err; it0 = idle_tx;
    i_frame = 16'hA55A; mem[0] = 32'h11223344; mem[1] = 32'hDEADBEEF;
    pulse_start();
    i_frame = 16'h0000;
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", o_busy); end
    wait_done(d0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_timeout got no o_done want o_done"); end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy got %b want 0", o_busy); end
    n_cmp++; if (byte_log.size() - base != 10) begin n_bad++; $display("FAIL basic_nbytes got %0d want 10", byte_log.size() - base); end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] got;
      got = (base + i < byte_log.size()) ? byte_log[base + i] : 8'hxx;
      n_cmp++; if (got !== e[i]) begin n_bad++; $display("FAIL basic_byte%0d got %h want %h", i, got, e[i]); end
    end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
    n_cmp++; if (rd_log.size() - rb != 4) begin n_bad++; $display("FAIL rd_cycles got %0d want 4", rd_log.size() - rb); end
    for (int i = 0; i < 4; i++) begin
      logic [DAB-1:0] ga, ea;
      ea = (i < 2) ? DAB'(0) : DAB'(1);
      ga = (rb + i < rd_log.size()) ? rd_log[rb + i] : 'x;
      n_cmp++; if (ga !== ea) begin n_bad++; $display("FAIL rd_addr%0d got %0d want %0d", i, ga, ea); end
    end
    n_cmp++; if (rd_overlap != ov0) begin n_bad++; $display("FAIL rd_during_tx got %0d want %0d", rd_overlap, ov0); end
    n_cmp++; if (stable_err != se0) begin n_bad++; $display("FAIL tx_data_stable got %0d want %0d", stable_err, se0); end
    n_cmp++; if (addr_err != ae0) begin n_bad++; $display("FAIL rd_addr_idle got %0d want %0d", addr_err, ae0); end
    n_cmp++; if (idle_tx != it0) begin n_bad++; $display("FAIL tx_while_idle got %0d want %0d", idle_tx, it0); end
  endtask

  task automatic test_ignore_start();
    int base, d0, it0, n_at_done;
    bit ok;
    base = byte_log.size(); d0 = done_cnt; it0 = idle_tx;
    i_frame = 16'hA55A; mem[0] = 32'h11223344; mem[1] = 32'hDEADBEEF;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_log.size() >= base + 3) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ign_byte3_timeout got none want byte 3"); end
    pulse_start();
    wait_done(d0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ign_timeout got no o_done want o_done"); end
    n_at_done = byte_log.size();
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); inj_done = 1'b1;
      @(negedge clk); inj_done = 1'b0;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_cmp++; if (n_at_done - base != 10) begin n_bad++; $display("FAIL ign_nbytes got %0d want 10", n_at_done - base); end
    n_cmp++; if (byte_log.size() != n_at_done) begin n_bad++; $display("FAIL ign_restart got %0d extra bytes want 0", byte_log.size() - n_at_done); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL ign_done_pulses got %0d want 1", done_cnt - d0); end
    n_cmp++; if (idle_tx != it0) begin n_bad++; $display("FAIL ign_tx_idle got %0d want %0d", idle_tx, it0); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy got %b want 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [10];
    int base, d0;
    bit ok;
    e = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    base = byte_log.size(); d0 = done_cnt;
    i_frame = 16'hA55A; mem[0] = 32'h11223344; mem[1] = 32'hDEADBEEF;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_log.size() >= base + 4) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_byte4_timeout got none want byte 4"); end
    repeat (3) @(negedge clk);
    rst = 1'b0; resp_clear = 1'b1;
    @(negedge clk);
    rst = 1'b1; resp_clear = 1'b0;
    n_cmp++; if (o_tx_start !== 1'b0) begin n_bad++; $display("FAIL rstmid_tx_start got %b want 0", o_tx_start); end
    n_cmp++; if (o_tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_tx_data got %h want 00", o_tx_data); end
    n_cmp++; if (o_debug_read_data !== 1'b0) begin n_bad++; $display("FAIL rstmid_rd_en got %b want 0", o_debug_read_data); end
    n_cmp++; if (o_debug_read_address !== '0) begin n_bad++; $display("FAIL rstmid_rd_addr got %h want 0", o_debug_read_address); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", o_done); end
    repeat (30) @(negedge clk);
    n_cmp++; if (byte_log.size() - base != 4) begin n_bad++; $display("FAIL rstmid_resume got %0d bytes want 4", byte_log.size() - base); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL rstmid_done_cnt got %0d want %0d", done_cnt, d0); end
    base = byte_log.size();
    pulse_start();
    wait_done(d0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rstmid_rerun_timeout got no o_done want o_done"); end
    n_cmp++; if (byte_log.size() - base != 10) begin n_bad++; $display("FAIL rstmid_nbytes got %0d want 10", byte_log.size() - base); end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] got;
      got = (base + i < byte_log.size()) ? byte_log[base + i] : 8'hxx;
      n_cmp++; if (got !== e[i]) begin n_bad++; $display("FAIL rstmid_byte%0d got %h want %h", i, got, e[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e [10];
    int base, d0;
    bit ok;
    e = '{8'h3C, 8'hC3, 8'h80, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h00, 8'hFF, 8'h10};
    for (int i = 0; i < 50 && o_busy; i++) @(negedge clk);
    base = byte_log.size(); d0 = done_cnt;
    i_frame = 16'h3CC3; mem[0] = 32'h80000001; mem[1] = 32'h7F00FF10;
    pulse_start();
    wait_done(d0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout got no o_done want o_done"); end
    n_cmp++; if (byte_log.size() - base != 10) begin n_bad++; $display("FAIL b2b_nbytes got %0d want 10", byte_log.size() - base); end
    for (int i = 0; i < 10; i++) begin
      logic [7:0] got;
      got = (base + i < byte_log.size()) ? byte_log[base + i] : 8'hxx;
      n_cmp++; if (got !== e[i]) begin n_bad++; $display("FAIL b2b_byte%0d got %h want %h", i, got, e[i]); end
    end
    @(negedge clk);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b want 0", o_busy); end
  endtask

  initial begin
    mem[0] = '0;
    mem[1] = '0;
    test_reset();
    test_basic_dump();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
